// File: rtl/tank_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tank_mover                                                               |
// | Debounced per-frame direction stepping of a tank, clamped to an arena.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tank_mover #(
    parameter int POS_W    = 6,
    parameter int HOLD_CNT = 4,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 2**POS_W-1,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 2**POS_W-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] initial_x,
    input  logic [POS_W-1:0] initial_y,
    input  logic [1:0]       initial_direction,
    input  logic [2:0]       direction_in,
    input  logic             valid_take_direction,
    input  logic             blocked,
    input  logic [1:0]       game_state,
    output logic [POS_W-1:0] tank_x_pos,
    output logic [POS_W-1:0] tank_y_pos,
    output logic [1:0]       direction_out,
    output logic             moved,
    output logic             bumped
);

    localparam logic [2:0]       c_UP        = 3'd0;
    localparam logic [2:0]       c_DOWN      = 3'd1;
    localparam logic [2:0]       c_LEFT      = 3'd2;
    localparam logic [2:0]       c_RIGHT     = 3'd3;
    localparam logic [2:0]       c_STAND     = 3'd4;
    localparam logic [1:0]       c_RELOAD    = 2'b10;
    localparam logic [7:0]       c_HOLD_LAST = 8'(HOLD_CNT-1);
    localparam logic [POS_W-1:0] c_X_MIN     = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] c_X_MAX     = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] c_Y_MIN     = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] c_Y_MAX     = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] c_ONE       = POS_W'(1);

    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic [1:0]       dir_q, dir_d;
    logic [2:0]       dir_last_q, dir_last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             moved_q, moved_d;
    logic             bumped_q, bumped_d;

    logic [2:0]       w_dir_norm;
    logic [POS_W-1:0] w_x_step;
    logic [POS_W-1:0] w_y_step;
    logic             w_at_edge;

    // Codes above STAND are illegal and collapse onto STAND.
    always_comb begin
        w_dir_norm = (direction_in > c_STAND) ? c_STAND : direction_in;
    end

    // Candidate target cell and whether the arena edge forbids it.
    always_comb begin
        w_x_step  = x_q;
        w_y_step  = y_q;
        w_at_edge = 1'b0;
        case (w_dir_norm)
            c_UP: begin
                w_at_edge = (y_q == c_Y_MIN);
                w_y_step  = y_q - c_ONE;
            end
            c_DOWN: begin
                w_at_edge = (y_q == c_Y_MAX);
                w_y_step  = y_q + c_ONE;
            end
            c_LEFT: begin
                w_at_edge = (x_q == c_X_MIN);
                w_x_step  = x_q - c_ONE;
            end
            c_RIGHT: begin
                w_at_edge = (x_q == c_X_MAX);
                w_x_step  = x_q + c_ONE;
            end
            default: begin
                w_at_edge = 1'b0;
            end
        endcase
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        dir_last_d = dir_last_q;
        cnt_d      = cnt_q;
        moved_d    = 1'b0;
        bumped_d   = 1'b0;
        if (game_state == c_RELOAD) begin
            x_d        = initial_x;
            y_d        = initial_y;
            dir_d      = initial_direction;
            dir_last_d = c_STAND;
            cnt_d      = 8'd0;
        end else if (valid_take_direction) begin
            if (w_dir_norm != dir_last_q) begin
                // New request: turn in place and restart the hold count.
                dir_last_d = w_dir_norm;
                cnt_d      = 8'd0;
                if (w_dir_norm != c_STAND) begin
                    dir_d = w_dir_norm[1:0];
                end
            end else if (w_dir_norm == c_STAND) begin
                cnt_d = 8'd0;
            end else if (cnt_q == c_HOLD_LAST) begin
                cnt_d = 8'd0;
                if (blocked || w_at_edge) begin
                    bumped_d = 1'b1;
                end else begin
                    x_d     = w_x_step;
                    y_d     = w_y_step;
                    moved_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= initial_x;
            y_q        <= initial_y;
            dir_q      <= initial_direction;
            dir_last_q <= c_STAND;
            cnt_q      <= 8'd0;
            moved_q    <= 1'b0;
            bumped_q   <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            dir_last_q <= dir_last_d;
            cnt_q      <= cnt_d;
            moved_q    <= moved_d;
            bumped_q   <= bumped_d;
        end
    end

    assign tank_x_pos    = x_q;
    assign tank_y_pos    = y_q;
    assign direction_out = dir_q;
    assign moved         = moved_q;
    assign bumped        = bumped_q;

endmodule
`default_nettype wire

// File: tb/tb_tank_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tank_mover                                                            |
// | Directed and random stimulus against a reference model, two configs.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tank_mover;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] initial_x = 6'd10;
    logic [5:0] initial_y = 6'd20;
    logic [1:0] initial_direction = 2'd3;
    logic [2:0] direction_in = 3'd4;
    logic       valid_take_direction = 1'b0;
    logic       blocked = 1'b0;
    logic [1:0] game_state = 2'b00;

    logic [5:0] x0, y0, x1, y1;
    logic [1:0] d0, d1;
    logic       m0, b0, m1, b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tank_mover u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .initial_x(initial_x), .initial_y(initial_y), .initial_direction(initial_direction),
        .direction_in(direction_in), .valid_take_direction(valid_take_direction),
        .blocked(blocked), .game_state(game_state),
        .tank_x_pos(x0), .tank_y_pos(y0), .direction_out(d0), .moved(m0), .bumped(b0)
    );

    tank_mover #(.HOLD_CNT(1), .X_MIN(2), .X_MAX(12), .Y_MIN(3), .Y_MAX(14)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .initial_x(initial_x), .initial_y(initial_y), .initial_direction(initial_direction),
        .direction_in(direction_in), .valid_take_direction(valid_take_direction),
        .blocked(blocked), .game_state(game_state),
        .tank_x_pos(x1), .tank_y_pos(y1), .direction_out(d1), .moved(m1), .bumped(b1)
    );

    // Reference model: one entry per instance, plain integer arithmetic.
    int hold_p[2] = '{4, 1};
    int xmin_p[2] = '{0, 2};
    int xmax_p[2] = '{63, 12};
    int ymin_p[2] = '{0, 3};
    int ymax_p[2] = '{63, 14};
    int mx[2], my[2], mdir[2], mlast[2], mcnt[2];
    int mmov[2], mbmp[2];

    function automatic void model_reset(int i);
        mx[i] = int'(initial_x);
        my[i] = int'(initial_y);
        mdir[i] = int'(initial_direction);
        mlast[i] = 4;
        mcnt[i] = 0;
        mmov[i] = 0;
        mbmp[i] = 0;
    endfunction

    function automatic void model_step(int i);
        int d, nx, ny;
        bit edge_hit;
        mmov[i] = 0;
        mbmp[i] = 0;
        if (game_state == 2'b10) begin
            model_reset(i);
        end else if (valid_take_direction) begin
            d = (int'(direction_in) > 4) ? 4 : int'(direction_in);
            if (d != mlast[i]) begin
                mlast[i] = d;
                mcnt[i] = 0;
                if (d != 4) mdir[i] = d;
            end else if (d == 4) begin
                mcnt[i] = 0;
            end else if (mcnt[i] == hold_p[i] - 1) begin
                mcnt[i] = 0;
                nx = mx[i];
                ny = my[i];
                edge_hit = 0;
                case (d)
                    0: begin edge_hit = (my[i] == ymin_p[i]); ny = my[i] - 1; end
                    1: begin edge_hit = (my[i] == ymax_p[i]); ny = my[i] + 1; end
                    2: begin edge_hit = (mx[i] == xmin_p[i]); nx = mx[i] - 1; end
                    default: begin edge_hit = (mx[i] == xmax_p[i]); nx = mx[i] + 1; end
                endcase
                if (blocked || edge_hit) begin
                    mbmp[i] = 1;
                end else begin
                    mx[i] = nx & 63;
                    my[i] = ny & 63;
                    mmov[i] = 1;
                end
            end else begin
                mcnt[i] = mcnt[i] + 1;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else model_step(i);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string nm, input int i, input logic [5:0] x, input logic [5:0] y,
                            input logic [1:0] d, input logic m, input logic b);
        check_val({nm, ".x"}, 32'(x), 32'(mx[i]));
        check_val({nm, ".y"}, 32'(y), 32'(my[i]));
        check_val({nm, ".dir"}, 32'(d), 32'(mdir[i]));
        check_val({nm, ".moved"}, 32'(m), 32'(mmov[i]));
        check_val({nm, ".bumped"}, 32'(b), 32'(mbmp[i]));
    endtask

    always @(negedge clk) begin
        cmp_inst("u0", 0, x0, y0, d0, m0, b0);
        cmp_inst("u1", 1, x1, y1, d1, m1, b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] d, input logic blk);
        direction_in = d;
        blocked = blk;
        valid_take_direction = 1'b1;
        tick();
        valid_take_direction = 1'b0;
        blocked = 1'b0;
    endtask

    task automatic strobe_n(input logic [2:0] d, input int n);
        for (int k = 0; k < n; k++) strobe(d, 1'b0);
    endtask

    task automatic reload(input logic [5:0] x, input logic [5:0] y, input logic [1:0] dir);
        initial_x = x;
        initial_y = y;
        initial_direction = dir;
        game_state = 2'b10;
        tick();
        game_state = 2'b00;
        valid_take_direction = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check_val("rst.x", 32'(x0), 32'd10);
        check_val("rst.y", 32'(y0), 32'd20);
        check_val("rst.dir", 32'(d0), 32'd3);
        check_val("rst.mv", 32'({m0, b0}), 32'd0);
        rst_n = 1'b1;
        tick();

        strobe(3'd0, 1'b0);
        check_val("up.turn", 32'(d0), 32'd0);
        strobe_n(3'd0, 3);
        check_val("up.early", 32'(y0), 32'd20);
        strobe(3'd0, 1'b0);
        check_val("up.y", 32'(y0), 32'd19);
        check_val("up.x", 32'(x0), 32'd10);
        check_val("up.moved", 32'(m0), 32'd1);
        tick();
        check_val("up.pulse", 32'(m0), 32'd0);

        reload(6'd63, 6'd0, 2'd1);
        strobe_n(3'd3, 5);
        check_val("xmax.x", 32'(x0), 32'd63);
        check_val("xmax.bump", 32'(b0), 32'd1);
        tick();
        check_val("xmax.pulse", 32'(b0), 32'd0);
        strobe_n(3'd0, 5);
        check_val("ymin.y", 32'(y0), 32'd0);
        check_val("ymin.bump", 32'(b0), 32'd1);

        reload(6'd10, 6'd20, 2'd3);
        strobe_n(3'd2, 3);
        check_val("l3.dir", 32'(d0), 32'd2);
        strobe(3'd1, 1'b0);
        check_val("dn.dir", 32'(d0), 32'd1);
        strobe_n(3'd2, 5);
        check_val("l5.dir", 32'(d0), 32'd2);
        check_val("l5.x", 32'(x0), 32'd9);

        strobe_n(3'd3, 4);
        strobe(3'd3, 1'b1);
        check_val("blk.bump", 32'(b0), 32'd1);
        check_val("blk.x", 32'(x0), 32'd9);
        strobe_n(3'd3, 4);
        check_val("unblk.x", 32'(x0), 32'd10);
        check_val("unblk.mv", 32'(m0), 32'd1);

        strobe_n(3'd3, 2);
        direction_in = 3'd3;
        valid_take_direction = 1'b1;
        reload(6'd10, 6'd20, 2'd3);
        check_val("rl.x", 32'(x0), 32'd10);
        check_val("rl.y", 32'(y0), 32'd20);
        check_val("rl.dir", 32'(d0), 32'd3);
        strobe_n(3'd3, 4);
        check_val("rl.nostep", 32'(x0), 32'd10);

        reload(6'd10, 6'd8, 2'd2);
        strobe(3'd6, 1'b0);
        check_val("h1.stand", 32'(m1), 32'd0);
        strobe(3'd0, 1'b0);
        check_val("h1.turn", 32'(m1), 32'd0);
        check_val("h1.dir", 32'(d1), 32'd0);
        strobe(3'd0, 1'b0);
        check_val("h1.step", 32'(m1), 32'd1);
        check_val("h1.y", 32'(y1), 32'd7);

        strobe_n(3'd3, 3);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        strobe_n(3'd3, 2);

        for (int c = 0; c < 3000; c++) begin
            if (rst_n && $urandom_range(99) == 0) begin
                rst_n = 1'b0;
            end else begin
                if (rst_n && $urandom_range(19) == 0) begin
                    initial_x = 6'($urandom_range(63));
                    initial_y = 6'($urandom_range(63));
                    initial_direction = 2'($urandom_range(3));
                end
                rst_n = 1'b1;
            end
            game_state = ($urandom_range(99) < 3) ? 2'b10 : 2'($urandom_range(1));
            valid_take_direction = ($urandom_range(1) == 1);
            direction_in = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(3) > 1 ? 3 : 2);
            blocked = ($urandom_range(4) == 0);
            tick();
        end
        rst_n = 1'b1;
        game_state = 2'b00;
        valid_take_direction = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tank_mover.md
# tank_mover

Parametrised tank movement controller. Sits between the game controller and the VGA renderer: takes one direction sample per frame, debounces it with a configurable hold count, then steps the tank one cell. Steps are clamped to configurable arena bounds and can be vetoed by a collision input. It reports position, facing, and one-cycle move/bump events.

## Interface
Parameters:
- POS_W, 6, width of x/y coordinates
- HOLD_CNT, 4, consecutive matching valid samples (after the direction is latched) required per step; legal range 1..255
- X_MIN, 0, lowest legal x
- X_MAX, 2**POS_W-1, highest legal x
- Y_MIN, 0, lowest legal y
- Y_MAX, 2**POS_W-1, highest legal y

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- initial_x  in  POS_W  spawn x; must be stable while rst_n is low and during reload
- initial_y  in  POS_W  spawn y
- initial_direction  in  2  spawn facing
- direction_in  in  3  requested direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 STAND; codes 5..7 are treated as STAND
- valid_take_direction  in  1  one-cycle strobe; direction_in is sampled when high
- blocked  in  1  the cell ahead in direction_in is occupied; sampled only with the strobe
- game_state  in  2  2'b10 means reload
- tank_x_pos  out  POS_W  tank x
- tank_y_pos  out  POS_W  tank y
- direction_out  out  2  facing, for the sprite
- moved  out  1  one-cycle pulse: a step was taken
- bumped  out  1  one-cycle pulse: a step was due but refused

## Operation
Internal state:
- dir_last, 3 bits: the latched direction.
- cnt, 8 bits: the count of matching samples.

Reload (game_state==2'b10) has priority over everything else, every cycle. It sets:
- position to initial_x/initial_y
- direction_out to initial_direction
- dir_last to STAND
- cnt to 0
- moved and bumped to 0

The strobe is ignored while reload is active.

On a strobe without reload, let d = direction_in, with 5..7 mapped to 4. Evaluate the first matching rule:
1. d != dir_last: set dir_last = d and cnt = 0. If d != STAND, direction_out = d[1:0] immediately (turn in place, no step).
2. d == STAND (and equal to dir_last): hold; cnt = 0.
3. cnt == HOLD_CNT-1: a step is due. Set cnt = 0, then:
   - If blocked is high, or the target is out of bounds, refuse the step. Bounds fail when y==Y_MIN for UP, y==Y_MAX for DOWN, x==X_MIN for LEFT, x==X_MAX for RIGHT. On refusal, position is unchanged and bumped pulses.
   - Otherwise move one cell and pulse moved. UP is y-1, DOWN is y+1, LEFT is x-1, RIGHT is x+1.
4. Otherwise: cnt = cnt+1.

Further rules:
- With no strobe, all state holds; moved and bumped are 0.
- Position arithmetic is POS_W bits. The bounds check guarantees no wrap-around can occur.
- With default bounds, the arena edges 0 and 2**POS_W-1 are enforced by the same bounds check.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - tank_x_pos = initial_x
  - tank_y_pos = initial_y
  - direction_out = initial_direction
  - dir_last = STAND
  - cnt = 0
  - moved = 0
  - bumped = 0
- All outputs are registered, with one-cycle latency from the strobe edge to the new position, direction_out, moved, or bumped.
- A first sample with a new direction plus HOLD_CNT further matching strobes produces the step. The step appears on the cycle after the (HOLD_CNT+1)-th strobe.
- moved and bumped are never both high, and each lasts exactly one cycle.
- A direction change or STAND at any count discards accumulated progress.
- Reload while counting discards progress.
- Reload coincident with a strobe: reload wins and the sample is lost.
- Reset asserted mid-count clears the count immediately, asynchronously.

## Test plan
- Reset with initial (10,20), direction 3. Strobe UP ×5 (HOLD_CNT=4) → direction_out=0 after the first strobe; y=19 and moved=1 one cycle after the fifth strobe; x=10.
- At x=X_MAX=63, strobe RIGHT ×5 → x stays 63 and bumped pulses once. Repeat at y=Y_MIN=0 with UP → same refusal, no wrap to 63.
- Strobe LEFT ×3, then DOWN, then LEFT ×5 → no step after the first run. direction_out goes 2, 1, 2. x decrements once, only after the final run.
- Strobe RIGHT ×5 with blocked=1 on the fifth strobe → bumped=1, x unchanged. Strobe ×4 more with blocked=0 → x+1.
- Mid-run (cnt=2), assert game_state=2'b10 for one cycle together with a strobe → position equals initial_x/initial_y and direction_out equals initial_direction. The next 4 matching strobes produce no step, because the first one re-latches the direction.
- HOLD_CNT=1, direction_in=6 strobed → treated as STAND, no step. Then UP ×2 → one step on the second strobe.
